// File: rtl/fp16_argmax.sv
// fp16_argmax: streaming argmax over NUM_CLASSES fp16 scores.
// One score is consumed per accepted beat; the winning class index and its
// score are published together with a single-cycle done pulse.
//
// Handshake: a beat transfers on a rising edge where score_valid && score_ready
// are both high. score_ready is a registered-state decode, so it never depends
// combinationally on score_valid. The producer must hold score stable while
// score_valid is high and the beat has not yet transferred.
module fp16_argmax #(
   parameter int NUM_CLASSES = 10,
   parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             score_valid,
   input  logic [15:0]      score,
   output logic             score_ready,
   output logic             busy,
   output logic             done,
   output logic [IDX_W-1:0] best_idx,
   output logic [15:0]      best_score
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      FINISH  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [IDX_W-1:0] count;
   logic [15:0]      run_score;
   logic [IDX_W-1:0] run_idx;

   logic             in_collect;
   logic             accept;
   logic             last_beat;
   logic             take;
   logic [15:0]      nxt_score;
   logic [IDX_W-1:0] nxt_idx;

   // Raw-bit fp16 ordering: sign first (+0 beats -0), then magnitude, with
   // the magnitude sense inverted for negatives. Equal bits are not greater.
   // Exponent sits above mantissa, so one 15-bit magnitude compare covers both.
   function automatic logic fp16_gt(input logic [15:0] a, input logic [15:0] b);
      logic res;
      if (a[15] != b[15])
         res = ~a[15];
      else if (a[15] == 1'b0)
         res = (a[14:0] > b[14:0]);
      else
         res = (a[14:0] < b[14:0]);
      return res;
   endfunction

   assign in_collect = (state == COLLECT);
   assign accept     = score_valid && in_collect;
   assign last_beat  = (count == LAST_IDX);

   // Running-maximum candidate for the beat being accepted this cycle.
   always_comb begin
      take      = (count == '0) || fp16_gt(score, run_score);
      nxt_score = run_score;
      nxt_idx   = run_idx;
      if (take) begin
         nxt_score = score;
         nxt_idx   = count;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state and state-decoded outputs.
   always_comb begin
      state_nxt   = state;
      score_ready = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (state)
         IDLE: begin
            if (start)
               state_nxt = COLLECT;
         end
         COLLECT: begin
            score_ready = 1'b1;
            busy        = 1'b1;
            if (accept && last_beat)
               state_nxt = FINISH;
         end
         FINISH: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Beat counter, running maximum and published result. The result is
   // written on the final accept so it is already visible while done is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count      <= '0;
         run_score  <= '0;
         run_idx    <= '0;
         best_idx   <= '0;
         best_score <= '0;
      end else begin
         if ((state == IDLE) && start)
            count <= '0;
         if (accept) begin
            run_score <= nxt_score;
            run_idx   <= nxt_idx;
            if (last_beat) begin
               best_idx   <= nxt_idx;
               best_score <= nxt_score;
            end else begin
               count <= count + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_fp16_argmax.sv
// Bench for fp16_argmax with NUM_CLASSES=4: directed cases plus random
// classifications, checked against an integer-key argmax reference model.
module tb_fp16_argmax;

   localparam int N     = 4;
   localparam int IDX_W = 2;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic             score_valid;
   logic [15:0]      score;
   logic             score_ready;
   logic             busy;
   logic             done;
   logic [IDX_W-1:0] best_idx;
   logic [15:0]      best_score;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int exp_done = 0;

   logic [IDX_W+15:0] exp_q[$];
   logic [IDX_W+15:0] held;
   logic [15:0]       cur[N];

   fp16_argmax #(.NUM_CLASSES(N), .IDX_W(IDX_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .score_valid (score_valid),
      .score       (score),
      .score_ready (score_ready),
      .busy        (busy),
      .done        (done),
      .best_idx    (best_idx),
      .best_score  (best_score)
   );

   // Clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Map fp16 bits onto a monotonic integer: negatives below positives,
   // -0 just below +0, larger negative magnitude lower.
   function automatic int key(input logic [15:0] v);
      if (v[15])
         return 32767 - int'(v[14:0]);
      else
         return 32768 + int'(v[14:0]);
   endfunction

   function automatic logic [IDX_W+15:0] model_argmax();
      int b = 0;
      for (int i = 1; i < N; i++)
         if (key(cur[i]) > key(cur[b]))
            b = i;
      return {IDX_W'(b), cur[b]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: pops the scoreboard on every done, otherwise checks that the
   // published result holds its last value.
   always @(negedge clk) begin
      if (!rst_n) begin
         held = '0;
      end else if (done) begin
         done_cnt++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL done_unexpected actual=%h_%h required=no_done", best_idx, best_score);
         end else begin
            held = exp_q.pop_front();
            if ({best_idx, best_score} !== held) begin
               errors++;
               $display("FAIL result actual=%h_%h required=%h_%h", best_idx, best_score,
                        held[IDX_W+15:16], held[15:0]);
            end
         end
      end else begin
         checks++;
         if ({best_idx, best_score} !== held) begin
            errors++;
            $display("FAIL best_hold actual=%h_%h required=%h_%h", best_idx, best_score,
                     held[IDX_W+15:16], held[15:0]);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) check("idle_timeout", 32'(busy), 32'd0);
   endtask

   task automatic send_beat(input logic [15:0] s);
      int n = 0;
      score_valid = 1'b1;
      score       = s;
      while (!score_ready && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) check("ready_timeout", 32'(score_ready), 32'd1);
      tick();
      score_valid = 1'b0;
      score       = 16'($urandom);
   endtask

   task automatic run_class(input int gap, input bit poke);
      wait_idle();
      exp_q.push_back(model_argmax());
      exp_done++;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("collect_entry", {30'd0, busy, score_ready}, 32'd3);
      for (int i = 0; i < N; i++) begin
         send_beat(cur[i]);
         if (i < N - 1) begin
            for (int g = 0; g < gap; g++) begin
               start = poke && (g == 0);
               tick();
               start = 1'b0;
            end
         end
      end
      check("done_after_last", {30'd0, done, score_ready}, 32'd2);
      tick();
      check("idle_after_done", {30'd0, done, busy}, 32'd0);
      check("done_count", 32'(done_cnt), 32'(exp_done));
   endtask

   task automatic set4(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] d);
      cur[0] = a; cur[1] = b; cur[2] = c; cur[3] = d;
   endtask

   function automatic logic [15:0] rand_score();
      logic [15:0] pool[6];
      pool[0] = 16'h0000; pool[1] = 16'h8000; pool[2] = 16'h3C00;
      pool[3] = 16'hBC00; pool[4] = 16'h7C00; pool[5] = 16'hFC00;
      if ($urandom_range(0, 1) == 0)
         return pool[$urandom_range(0, 5)];
      else
         return 16'($urandom);
   endfunction

   // Stimulus.
   initial begin
      rst_n       = 1'b0;
      start       = 1'b0;
      score_valid = 1'b0;
      score       = '0;
      repeat (3) tick();
      check("reset_outputs", {11'd0, score_ready, busy, done, best_idx, best_score}, 32'd0);
      rst_n = 1'b1;
      tick();
      check("ready_before_start", 32'(score_ready), 32'd0);

      set4(16'h3C00, 16'h4000, 16'h3E00, 16'h3800); run_class(0, 1'b0);
      set4(16'hC000, 16'hBC00, 16'hC200, 16'hC400); run_class(0, 1'b0);
      set4(16'h4000, 16'h3C00, 16'h4000, 16'h3800); run_class(0, 1'b0);
      set4(16'h8000, 16'h0000, 16'h8000, 16'h8000); run_class(0, 1'b0);
      set4(16'h3BFF, 16'h3C00, 16'h3C01, 16'h3C00); run_class(0, 1'b0);
      set4(16'h3C00, 16'h4000, 16'h3E00, 16'h3800); run_class(3, 1'b1);

      // Reset in the middle of a classification.
      wait_idle();
      start = 1'b1;
      tick();
      start = 1'b0;
      send_beat(16'h4000);
      send_beat(16'h3C00);
      rst_n = 1'b0;
      #1;
      check("mid_reset_outputs", {11'd0, score_ready, busy, done, best_idx, best_score}, 32'd0);
      tick();
      tick();
      check("mid_reset_hold", {11'd0, score_ready, busy, done, best_idx, best_score}, 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("ready_after_release", {30'd0, score_ready, busy}, 32'd0);
      end
      set4(16'hC000, 16'hBC00, 16'hC200, 16'hC400); run_class(0, 1'b0);

      // Random classifications.
      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < N; i++) cur[i] = rand_score();
         run_class($urandom_range(0, 2), bit'($urandom_range(0, 1)));
      end

      repeat (4) tick();
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
